// File: rtl/traffic_ctrl_param.sv
// Actuated main/local intersection controller with prescaled phase timing and latched pedestrian calls.
// Defining TRAFFIC_PREEMPT_EN adds the 'preempt' input that forces the intersection back to main green.
module traffic_ctrl_param #(
   parameter int unsigned TICK_DIV    = 10,
   parameter int unsigned MAIN_GREEN  = 6,
   parameter int unsigned LOCAL_GREEN = 4,
   parameter int unsigned YELLOW      = 2,
   parameter int unsigned ALL_RED     = 1,
   parameter int unsigned PED_WALK    = 3,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_a,
   input  logic       local_req,
   input  logic       ped_req_main,
   input  logic       ped_req_local,
`ifdef TRAFFIC_PREEMPT_EN
   input  logic       preempt,
`endif
   output logic [2:0] main_lights,
   output logic [2:0] local_lights,
   output logic       ped_main_walk,
   output logic       ped_local_walk,
   output logic [2:0] phase,
   output logic       tick
);

   typedef enum logic [2:0] {
      MAIN_G  = 3'd0,
      MAIN_Y  = 3'd1,
      AR1     = 3'd2,
      LOCAL_G = 3'd3,
      LOCAL_Y = 3'd4,
      AR2     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] MG_FULL   = CNT_W'(MAIN_GREEN);
   localparam logic [CNT_W-1:0] MG_LAST   = CNT_W'(MAIN_GREEN - 1);
   localparam logic [CNT_W-1:0] LG_LAST   = CNT_W'(LOCAL_GREEN - 1);
   localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED - 1);
   localparam logic [CNT_W-1:0] PW_LAST   = CNT_W'(PED_WALK - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] presc_q, presc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q;
   logic             lreq_q, lreq_d;
   logic             pm_q, pm_d;
   logic             pl_q, pl_d;
   logic             pmw_q, pmw_d;
   logic             plw_q, plw_d;
   logic [2:0]       main_q, local_q;
   logic [5:0]       headsD;
   logic             demand;
   logic             entering;
   logic             plClear;

   // Head colours {main, local} shown while in a given state.
   function automatic logic [5:0] headsFor(input state_t s);
      case (s)
         MAIN_G:  headsFor = {3'b001, 3'b100};
         MAIN_Y:  headsFor = {3'b010, 3'b100};
         LOCAL_G: headsFor = {3'b100, 3'b001};
         LOCAL_Y: headsFor = {3'b100, 3'b010};
         default: headsFor = {3'b100, 3'b100};
      endcase
   endfunction

   // Next state, duration counter, walk timers and request latches.
   always_comb begin
      presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + 1'b1;
      demand  = local_req | lreq_q | pm_q;
      state_d = state_q;
      case (state_q)
         MAIN_G:  if ((cnt_q == MG_FULL || (tick_q && cnt_q == MG_LAST)) && demand) state_d = MAIN_Y;
         MAIN_Y:  if (tick_q && cnt_q == Y_LAST)  state_d = AR1;
         AR1:     if (tick_q && cnt_q == AR_LAST) state_d = LOCAL_G;
         LOCAL_G: if (tick_q && cnt_q == LG_LAST) state_d = LOCAL_Y;
         LOCAL_Y: if (tick_q && cnt_q == Y_LAST)  state_d = AR2;
         AR2:     if (tick_q && cnt_q == AR_LAST) state_d = MAIN_G;
         default: state_d = MAIN_G;
      endcase
`ifdef TRAFFIC_PREEMPT_EN
      if (preempt) begin
         if (state_q == MAIN_G)       state_d = MAIN_G;
         else if (state_q == LOCAL_G) state_d = LOCAL_Y;
      end
`endif
      entering = (state_d != state_q);

      cnt_d = cnt_q;
      if (entering)
         cnt_d = '0;
      else if (tick_q && !(state_q == MAIN_G && cnt_q == MG_FULL))
         cnt_d = cnt_q + 1'b1;

      // A walk is granted only from the latch value seen at phase entry.
      pmw_d = pmw_q;
      plw_d = plw_q;
      if (tick_q && cnt_q == PW_LAST) begin
         pmw_d = 1'b0;
         plw_d = 1'b0;
      end
      if (entering) begin
         pmw_d = (state_d == LOCAL_G) & pm_q;
         plw_d = (state_d == MAIN_G) & pl_q;
      end

      plClear = entering && (state_d == MAIN_G);
`ifdef TRAFFIC_PREEMPT_EN
      if (preempt && state_d == MAIN_G) begin
         plw_d   = 1'b0;
         plClear = 1'b0;
      end
`endif
      lreq_d = ((entering && state_d == LOCAL_G) ? 1'b0 : lreq_q) | local_req;
      pm_d   = ((entering && state_d == LOCAL_G) ? 1'b0 : pm_q) | ped_req_main;
      pl_d   = (plClear ? 1'b0 : pl_q) | ped_req_local;
      headsD = headsFor(state_d);
   end

   // State and registered outputs update together on the same edge.
   always_ff @(posedge clk) begin
      if (rst_a) begin
         state_q <= MAIN_G;
         presc_q <= '0;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         lreq_q  <= 1'b0;
         pm_q    <= 1'b0;
         pl_q    <= 1'b0;
         pmw_q   <= 1'b0;
         plw_q   <= 1'b0;
         main_q  <= 3'b001;
         local_q <= 3'b100;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         tick_q  <= (presc_d == TICK_LAST);
         lreq_q  <= lreq_d;
         pm_q    <= pm_d;
         pl_q    <= pl_d;
         pmw_q   <= pmw_d;
         plw_q   <= plw_d;
         main_q  <= headsD[5:3];
         local_q <= headsD[2:0];
      end
   end

   assign main_lights    = main_q;
   assign local_lights   = local_q;
   assign ped_main_walk  = pmw_q;
   assign ped_local_walk = plw_q;
   assign phase          = state_q;
   assign tick           = tick_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: directed timing checks plus randomized traffic against a phase-table model.
module tb_traffic_ctrl_param;

   localparam int TD = 2;
   localparam int MG = 4;
   localparam int LG = 3;
   localparam int YL = 2;
   localparam int AR = 1;
   localparam int PW = 2;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1;
   logic       local_req = 1'b0;
   logic       ped_req_main = 1'b0;
   logic       ped_req_local = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
   logic       preempt = 1'b0;
`endif
   logic [2:0] main_lights, local_lights, phase;
   logic       ped_main_walk, ped_local_walk, tick;

   int vectors = 0;
   int fails = 0;
   int cur = 0;
   bit checkEn = 1'b0;

   traffic_ctrl_param #(
      .TICK_DIV(TD), .MAIN_GREEN(MG), .LOCAL_GREEN(LG),
      .YELLOW(YL), .ALL_RED(AR), .PED_WALK(PW), .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst_a(rst_a),
      .local_req(local_req),
      .ped_req_main(ped_req_main),
      .ped_req_local(ped_req_local),
`ifdef TRAFFIC_PREEMPT_EN
      .preempt(preempt),
`endif
      .main_lights(main_lights),
      .local_lights(local_lights),
      .ped_main_walk(ped_main_walk),
      .ped_local_walk(ped_local_walk),
      .phase(phase),
      .tick(tick)
   );

   always #5 clk = ~clk;

   // Reference model: phase index, ticks spent in the phase, cycle position within a tick.
   logic [2:0] mainTab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
   logic [2:0] localTab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
   int         dur     [6] = '{MG, YL, AR, LG, YL, AR};
   int mPhase = 0, mTicks = 0, mPresc = 0;
   bit mL = 0, mPM = 0, mPL = 0, mGrantM = 0, mGrantL = 0;

   always @(posedge clk) begin : modelStep
      int nxt, tk, ticksN;
      bit pre, l, pm, pl, gm, gl;
      if (rst_a) begin
         mPhase <= 0; mTicks <= 0; mPresc <= 0;
         mL <= 0; mPM <= 0; mPL <= 0; mGrantM <= 0; mGrantL <= 0;
      end else begin
         pre = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
         pre = preempt;
`endif
         tk = (mPresc == TD - 1) ? 1 : 0;
         l = mL; pm = mPM; pl = mPL; gm = mGrantM; gl = mGrantL;
         nxt = mPhase;
         if (mPhase == 0) begin
            if (mTicks + tk >= MG && (local_req || mL || mPM)) nxt = 1;
         end else if (tk == 1 && mTicks + 1 == dur[mPhase]) begin
            nxt = (mPhase + 1) % 6;
         end
         if (pre && mPhase == 0) nxt = 0;
         if (pre && mPhase == 3) nxt = 4;
         if (nxt != mPhase) begin
            ticksN = 0;
            if (nxt == 3) begin gm = mPM; l = 0; pm = 0; end
            if (nxt == 0) begin gl = mPL && !pre; if (!pre) pl = 0; end
         end else begin
            ticksN = mTicks + tk;
         end
         if (pre && nxt == 0) gl = 0;
         mPhase <= nxt; mTicks <= ticksN; mPresc <= (mPresc + 1) % TD;
         mL <= l | local_req; mPM <= pm | ped_req_main; mPL <= pl | ped_req_local;
         mGrantM <= gm; mGrantL <= gl;
      end
   end

   // Per-cycle comparison of every output against the model, plus the safety invariant.
   always @(negedge clk) begin : compare
      logic [13:0] got, exp;
      if (checkEn) begin
         got = {main_lights, local_lights, ped_main_walk, ped_local_walk, phase, tick};
         exp = {mainTab[mPhase], localTab[mPhase],
                (mPhase == 3 && mGrantM && mTicks < PW),
                (mPhase == 0 && mGrantL && mTicks < PW),
                3'(mPhase), (mPresc == TD - 1)};
         vectors++;
         if (got !== exp) begin
            fails++;
            $display("[TB] FAIL model t=%0t got m=%b l=%b pw=%b%b ph=%0d tk=%b expected m=%b l=%b pw=%b%b ph=%0d tk=%b",
                     $time, got[13:11], got[10:8], got[7], got[6], got[5:3], got[0],
                     exp[13:11], exp[10:8], exp[7], exp[6], exp[5:3], exp[0]);
         end
         vectors++;
         assert (!(main_lights != 3'b100 && local_lights != 3'b100) && !(ped_main_walk && ped_local_walk))
         else begin
            fails++;
            $display("[TB] FAIL safety t=%0t got m=%b l=%b walks=%b%b required one head red and one walk off",
                     $time, main_lights, local_lights, ped_main_walk, ped_local_walk);
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
      end
   endtask

   task automatic advance(input int n);
      repeat (n) @(negedge clk);
      cur += n;
   endtask

   task automatic gotoCycle(input int c);
      if (c > cur) advance(c - cur);
   endtask

   // Assert reset for one edge; returns in cycle 0 with reset released.
   task automatic doReset();
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      checkEn = 1'b1;
      rst_a = 1'b0;
      cur = 0;
   endtask

   task automatic waitPhase(input int target, input int limit, input string name);
      int n = 0;
      while (int'(phase) != target && n < limit) begin
         advance(1);
         n++;
      end
      checkOutput(name, int'(phase), target);
   endtask

   task automatic applyStimulus();
      local_req     = ($urandom % 20) == 0;
      ped_req_main  = ($urandom % 25) == 0;
      ped_req_local = ($urandom % 25) == 0;
      rst_a         = ($urandom % 400) == 0;
`ifdef TRAFFIC_PREEMPT_EN
      if (($urandom % 60) == 0) preempt = ~preempt;
`endif
      advance(1);
   endtask

   task automatic clearInputs();
      local_req = 0; ped_req_main = 0; ped_req_local = 0; rst_a = 0;
`ifdef TRAFFIC_PREEMPT_EN
      preempt = 0;
`endif
   endtask

   initial begin : watchdog
      #1000000;
      fails++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin : stimulus
      int ticks, n;
      bit mainSteady;

      // Reset state and idle behaviour.
      doReset();
      checkOutput("reset phase", int'(phase), 0);
      checkOutput("reset main", int'(main_lights), 3'b001);
      checkOutput("reset local", int'(local_lights), 3'b100);
      checkOutput("reset tick", int'(tick), 0);
      ticks = 0;
      mainSteady = 1;
      for (int i = 0; i < 100; i++) begin
         ticks += int'(tick);
         if (main_lights != 3'b001 || local_lights != 3'b100) mainSteady = 0;
         advance(1);
      end
      checkOutput("idle tick count", ticks, 50);
      checkOutput("idle main green", int'(mainSteady), 1);

      // Vehicle demand: full cycle with literal entry times.
      doReset();
      gotoCycle(3); local_req = 1;
      gotoCycle(4); local_req = 0;
      gotoCycle(7);  checkOutput("c7 phase", int'(phase), 0);
      gotoCycle(8);  checkOutput("c8 phase", int'(phase), 1);
      checkOutput("c8 main", int'(main_lights), 3'b010);
      gotoCycle(12); checkOutput("c12 phase", int'(phase), 2);
      gotoCycle(14); checkOutput("c14 phase", int'(phase), 3);
      checkOutput("c14 local", int'(local_lights), 3'b001);
      checkOutput("c14 main", int'(main_lights), 3'b100);
      gotoCycle(20); checkOutput("c20 phase", int'(phase), 4);
      checkOutput("c20 local", int'(local_lights), 3'b010);
      gotoCycle(24); checkOutput("c24 phase", int'(phase), 5);
      gotoCycle(26); checkOutput("c26 phase", int'(phase), 0);
      checkOutput("c26 main", int'(main_lights), 3'b001);

      // Pedestrian crossing the main road drives the cycle by itself.
      doReset();
      gotoCycle(3); ped_req_main = 1;
      gotoCycle(4); ped_req_main = 0;
      gotoCycle(13); checkOutput("pm c13 walk", int'(ped_main_walk), 0);
      gotoCycle(14); checkOutput("pm c14 walk", int'(ped_main_walk), 1);
      gotoCycle(17); checkOutput("pm c17 walk", int'(ped_main_walk), 1);
      gotoCycle(18); checkOutput("pm c18 walk", int'(ped_main_walk), 0);
      gotoCycle(26); checkOutput("pm c26 phase", int'(phase), 0);
      gotoCycle(60); checkOutput("pm latch cleared", int'(phase), 0);

      // Pedestrian crossing the local road: no forced cycle, walk on next main green.
      doReset();
      gotoCycle(3); ped_req_local = 1;
      gotoCycle(4); ped_req_local = 0;
      gotoCycle(40); checkOutput("pl holds main", int'(phase), 0);
      checkOutput("pl no walk yet", int'(ped_local_walk), 0);
      local_req = 1; advance(1); local_req = 0;
      waitPhase(3, 60, "pl reach local green");
      waitPhase(0, 60, "pl back to main green");
      n = 0;
      while (ped_local_walk && n < 20) begin
         n++;
         advance(1);
      end
      checkOutput("pl walk length", n, 4);

      // Reset in the middle of local green.
      doReset();
      gotoCycle(3); local_req = 1;
      gotoCycle(4); local_req = 0;
      gotoCycle(15); ped_req_main = 1; local_req = 1;
      gotoCycle(16); ped_req_main = 0; local_req = 0; rst_a = 1;
      advance(1);
      checkOutput("midreset phase", int'(phase), 0);
      checkOutput("midreset main", int'(main_lights), 3'b001);
      checkOutput("midreset local", int'(local_lights), 3'b100);
      checkOutput("midreset walks", int'({ped_main_walk, ped_local_walk}), 0);
      rst_a = 0; cur = 0;
      gotoCycle(40); checkOutput("midreset latches", int'(phase), 0);

`ifdef TRAFFIC_PREEMPT_EN
      // Preemption one tick into local green.
      doReset();
      gotoCycle(3); local_req = 1;
      gotoCycle(4); local_req = 0;
      gotoCycle(15); preempt = 1;
      gotoCycle(16); checkOutput("pre local_y", int'(phase), 4);
      gotoCycle(22); checkOutput("pre main_g", int'(phase), 0);
      gotoCycle(25); local_req = 1;
      gotoCycle(26); local_req = 0;
      gotoCycle(40); checkOutput("pre held", int'(phase), 0);
      preempt = 0;
      waitPhase(1, 10, "pre released");
`endif

      // Randomized traffic checked against the model every cycle.
      doReset();
      for (int i = 0; i < 3000; i++) applyStimulus();
      clearInputs();
      advance(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
